// File: rtl/prod_sched.sv
// Round-robin scheduler sharing one unary Product_Block among N_REQ requesters.
// Optional zero-operand bypass: define PROD_SCHED_ZERO_SKIP_EN.
module prod_sched #(
  parameter int N_REQ  = 4,
  parameter int WINDOW = 225,
  parameter int CW     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [4*N_REQ-1:0]       req_w,
  input  logic [4*N_REQ-1:0]       req_x,
  output logic [N_REQ-1:0]         gnt,
  output logic                     pb_in_rdy,
  output logic [3:0]               pb_w,
  output logic [3:0]               pb_x,
  input  logic                     pb_out,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [CW-1:0]            rsp_prod,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(WINDOW + 1);

`ifdef PROD_SCHED_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [IW-1:0]  last_gnt, id_l, sel, rid_q;
  logic           found, rest;
  logic [3:0]     w_l, x_l, w_sel, x_sel;
  logic [CW-1:0]  pcnt, prod_q;
  logic [WW-1:0]  wcnt;
  int unsigned    idx;

  // First pending request searching upward from last_gnt+1, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_gnt) + k) % N_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign w_sel = req_w[4*sel +: 4];
  assign x_sel = req_x[4*sel +: 4];

  // The IDLE cycle right after DONE never arbitrates, giving a WINDOW+4 issue period.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (found && !rest)
              state_d = (ZSKIP && (w_sel == 4'd0 || x_sel == 4'd0)) ? DONE : LOAD;
      LOAD: state_d = RUN;
      RUN:  if (wcnt == WW'(WINDOW - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= IW'(N_REQ - 1);
      id_l     <= '0;
      rid_q    <= '0;
      w_l      <= '0;
      x_l      <= '0;
      pcnt     <= '0;
      prod_q   <= '0;
      wcnt     <= '0;
      rest     <= 1'b0;
    end else begin
      rest <= (state == DONE);
      case (state)
        IDLE: if (found && !rest) begin
          id_l <= sel;
          w_l  <= w_sel;
          x_l  <= x_sel;
          pcnt <= '0;
          wcnt <= '0;
        end
        LOAD: begin
          pcnt <= '0;
          wcnt <= '0;
        end
        RUN: begin
          wcnt <= wcnt + 1'b1;
          if (pb_out && pcnt != '1) pcnt <= pcnt + 1'b1;
        end
        DONE: begin
          last_gnt <= id_l;
          rid_q    <= id_l;
          prod_q   <= pcnt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt       = '0;
    pb_in_rdy = 1'b0;
    pb_w      = '0;
    pb_x      = '0;
    rsp_valid = 1'b0;
    rsp_id    = rid_q;
    rsp_prod  = prod_q;
    busy      = (state != IDLE);
    if (state != IDLE) gnt[id_l] = 1'b1;
    if (state == LOAD || state == RUN) begin
      pb_w = w_l;
      pb_x = x_l;
    end
    if (state == LOAD) pb_in_rdy = 1'b1;
    if (state == DONE) begin
      rsp_valid = 1'b1;
      rsp_id    = id_l;
      rsp_prod  = pcnt;
    end
  end

endmodule

// File: tb/tb_prod_sched.sv
// Directed self-checking bench for prod_sched with a unary product-block model.
module tb_prod_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_w = '0, req_x = '0;
  logic [3:0]  gnt;
  logic        pb_in_rdy, pb_out, rsp_valid, busy;
  logic [3:0]  pb_w, pb_x;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        stray = 1'b0;
  int          rem;

  logic [3:0]  req4 = '0;
  logic [15:0] rw4 = '0, rx4 = '0;
  logic [3:0]  gnt4, w4o, x4o, rp4;
  logic        rdy4, pb_out4, rv4, busy4;
  logic [1:0]  rid4;
  int          rem4;

  int          errors = 0, checks = 0;
  int          lat;
  logic [7:0]  prod;
  logic [1:0]  rid;
  bit          rdy_seen;

  always #5 clk = ~clk;

  prod_sched #(.N_REQ(4), .WINDOW(225), .CW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_w(req_w), .req_x(req_x),
    .gnt(gnt), .pb_in_rdy(pb_in_rdy), .pb_w(pb_w), .pb_x(pb_x), .pb_out(pb_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod), .busy(busy)
  );

  prod_sched #(.N_REQ(4), .WINDOW(225), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .req_w(rw4), .req_x(rx4),
    .gnt(gnt4), .pb_in_rdy(rdy4), .pb_w(w4o), .pb_x(x4o), .pb_out(pb_out4),
    .rsp_valid(rv4), .rsp_id(rid4), .rsp_prod(rp4), .busy(busy4)
  );

  // Product block: w*x pulses starting the cycle after pb_in_rdy.
  always @(posedge clk) begin
    if (reset) rem <= 0;
    else if (pb_in_rdy) rem <= pb_w * pb_x;
    else if (rem > 0) rem <= rem - 1;
  end
  assign pb_out = (rem > 0) | stray;

  always @(posedge clk) begin
    if (reset) rem4 <= 0;
    else if (rdy4) rem4 <= w4o * x4o;
    else if (rem4 > 0) rem4 <= rem4 - 1;
  end
  assign pb_out4 = (rem4 > 0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int id, input logic [3:0] w, input logic [3:0] x);
    req = '0;
    repeat (2) tick();
    req_w = '0;
    req_x = '0;
    req_w[4*id +: 4] = w;
    req_x[4*id +: 4] = x;
    req[id] = 1'b1;
    lat = 0;
    rdy_seen = 1'b0;
    while (!rsp_valid && lat < 400) begin
      tick();
      lat++;
      if (pb_in_rdy) rdy_seen = 1'b1;
    end
    prod = rsp_prod;
    rid = rsp_id;
    req = '0;
  endtask

  task automatic test_reset;
    logic [24:0] v;
    reset = 1'b1;
    repeat (2) tick();
    v = {gnt, pb_in_rdy, pb_w, pb_x, rsp_valid, rsp_id, rsp_prod, busy};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    int n;
    req = '0;
    repeat (2) tick();
    req_w = 16'h0300;
    req_x = 16'h0500;
    req = 4'b0100;
    tick();
    checks++;
    if (pb_in_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", pb_in_rdy); end
    checks++;
    if ({pb_w, pb_x} !== 8'h35) begin errors++; $display("FAIL single_ops: got %h want 35", {pb_w, pb_x}); end
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    req_w = '1;
    req_x = '1;
    tick();
    checks++;
    if ({pb_in_rdy, pb_w, pb_x} !== 9'h035) begin
      errors++; $display("FAIL single_run: got %h want 035", {pb_in_rdy, pb_w, pb_x});
    end
    n = 2;
    while (!rsp_valid && n < 400) begin tick(); n++; end
    checks++;
    if (n !== 227) begin errors++; $display("FAIL single_lat: got %0d want 227", n); end
    checks++;
    if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", rsp_id); end
    checks++;
    if (rsp_prod !== 8'd15) begin errors++; $display("FAIL single_prod: got %0d want 15", rsp_prod); end
    req = '0;
    tick();
    checks++;
    if ({gnt, busy, rsp_valid, pb_w} !== 10'h0) begin
      errors++; $display("FAIL single_after: got %h want 0", {gnt, busy, rsp_valid, pb_w});
    end
    checks++;
    if (rsp_prod !== 8'd15) begin errors++; $display("FAIL single_hold: got %0d want 15", rsp_prod); end
  endtask

  task automatic test_fairness;
    int n, prev;
    req_w = 16'h4321;
    req_x = 16'h2222;
    req = 4'hF;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fair_reset_wins: got %b want 0", busy); end
    reset = 1'b0;
    n = 0;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      while (!rsp_valid && n < 1300) begin tick(); n++; end
      checks++;
      if (rsp_id !== 2'(k % 4)) begin
        errors++; $display("FAIL fair_id%0d: got %0d want %0d", k, rsp_id, k % 4);
      end
      checks++;
      if (rsp_prod !== 8'((k % 4 + 1) * 2)) begin
        errors++; $display("FAIL fair_prod%0d: got %0d want %0d", k, rsp_prod, (k % 4 + 1) * 2);
      end
      checks++;
      if (n - prev !== ((k == 0) ? 227 : 229)) begin
        errors++; $display("FAIL fair_gap%0d: got %0d want %0d", k, n - prev, (k == 0) ? 227 : 229);
      end
      prev = n;
      tick();
      n++;
    end
    req = '0;
  endtask

  task automatic test_extremes;
    int n;
    run_one(1, 4'd15, 4'd15);
    checks++;
    if (prod !== 8'd225) begin errors++; $display("FAIL ext_prod: got %0d want 225", prod); end
    checks++;
    if (lat !== 227) begin errors++; $display("FAIL ext_lat: got %0d want 227", lat); end
    rw4 = 16'h0004;
    rx4 = 16'h0005;
    req4 = 4'b0001;
    n = 0;
    while (!rv4 && n < 400) begin tick(); n++; end
    req4 = '0;
    checks++;
    if (rp4 !== 4'd15) begin errors++; $display("FAIL sat_prod: got %0d want 15", rp4); end
    checks++;
    if (n !== 227) begin errors++; $display("FAIL sat_lat: got %0d want 227", n); end
  endtask

  task automatic test_stray;
    int n;
    req = '0;
    stray = 1'b1;
    repeat (2) tick();
    req_w = 16'h1000;
    req_x = 16'h1000;
    req = 4'b1000;
    tick();
    stray = 1'b0;
    n = 1;
    while (!rsp_valid && n < 400) begin tick(); n++; end
    stray = 1'b1;
    checks++;
    if (n !== 227) begin errors++; $display("FAIL stray_lat: got %0d want 227", n); end
    checks++;
    if (rsp_prod !== 8'd1) begin errors++; $display("FAIL stray_done: got %0d want 1", rsp_prod); end
    req = '0;
    tick();
    checks++;
    if (rsp_prod !== 8'd1) begin errors++; $display("FAIL stray_hold: got %0d want 1", rsp_prod); end
    tick();
    stray = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [24:0] v;
    bit seen;
    req = '0;
    repeat (2) tick();
    req_w = 16'h0020;
    req_x = 16'h0030;
    req = 4'b0010;
    tick();
    repeat (100) tick();
    checks++;
    if ({busy, gnt} !== 5'b10010) begin
      errors++; $display("FAIL mid_busy: got %b want 10010", {busy, gnt});
    end
    reset = 1'b1;
    tick();
    v = {gnt, pb_in_rdy, pb_w, pb_x, rsp_valid, rsp_id, rsp_prod, busy};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL mid_outputs: got %h want 0", v); end
    reset = 1'b0;
    req = '0;
    seen = 1'b0;
    repeat (300) begin tick(); if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b want 0", seen); end
    run_one(0, 4'd2, 4'd6);
    checks++;
    if (lat !== 227) begin errors++; $display("FAIL mid_next_lat: got %0d want 227", lat); end
    checks++;
    if (prod !== 8'd12) begin errors++; $display("FAIL mid_next_prod: got %0d want 12", prod); end
    checks++;
    if (rid !== 2'd0) begin errors++; $display("FAIL mid_next_id: got %0d want 0", rid); end
  endtask

  task automatic test_zero;
    int  exp_lat;
    bit  exp_rdy;
`ifdef PROD_SCHED_ZERO_SKIP_EN
    exp_lat = 1;
    exp_rdy = 1'b0;
`else
    exp_lat = 227;
    exp_rdy = 1'b1;
`endif
    run_one(2, 4'd0, 4'd7);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL zero_lat: got %0d want %0d", lat, exp_lat); end
    checks++;
    if (prod !== 8'd0) begin errors++; $display("FAIL zero_prod: got %0d want 0", prod); end
    checks++;
    if (rdy_seen !== exp_rdy) begin
      errors++; $display("FAIL zero_rdy: got %b want %b", rdy_seen, exp_rdy);
    end
    checks++;
    if (rid !== 2'd2) begin errors++; $display("FAIL zero_id: got %0d want 2", rid); end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_extremes();
    test_stray();
    test_reset_mid();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prod_sched.md
# prod_sched

Round-robin scheduler that shares one Product_Block unary multiplier among `N_REQ` requesters. It latches a granted requester's 4-bit `w`/`x` operands and fires them into the multiplier with a one-cycle `in_rdy` pulse. It then counts the multiplier's `out` pulses over a fixed window and returns the binary product count to that requester. It sits between the weight/activation sequencing logic and the shared product datapath.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `WINDOW`, 225: RUN-phase length in cycles; covers the 15×15 worst case.
- `CW`, 8: product count width.
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `req` in N_REQ: request per requester; held high until that requester's `rsp_valid`.
- `req_w` in 4·N_REQ: weight operand; requester i uses bits [4i+3:4i].
- `req_x` in 4·N_REQ: input operand; same packing as `req_w`.
- `gnt` out N_REQ: one-hot grant, high from LOAD through DONE.
- `pb_in_rdy` out 1: start pulse to the product block.
- `pb_w` out 4: weight driven to the product block.
- `pb_x` out 4: input driven to the product block.
- `pb_out` in 1: unary pulse stream from the product block.
- `rsp_valid` out 1: one-cycle result strobe.
- `rsp_id` out $clog2(N_REQ): index of the requester the result belongs to.
- `rsp_prod` out CW: counted product.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Outputs are decoded from registered state, Moore style.
- **IDLE**
  - If any `req` bit is high, pick the first set bit searching upward from `last_gnt+1` (mod N_REQ).
  - Latch that requester's `w`/`x` and its index, then go to LOAD.
  - If no `req` bit is high, stay in IDLE.
- **LOAD**
  - `gnt[id]`=1, `pb_in_rdy`=1, `pb_w`/`pb_x` = latched operands.
  - Clear the pulse counter and the window counter, then go to RUN.
- **RUN**
  - `pb_w`/`pb_x` stay at the latched values; `pb_in_rdy`=0.
  - Each cycle, the pulse counter increments when `pb_out`=1.
  - The pulse counter saturates at 2^CW−1 with no wrap.
  - The window counter increments each cycle; go to DONE after exactly WINDOW RUN cycles.
- **DONE**
  - `rsp_valid`=1, `rsp_id` = latched index, `rsp_prod` = pulse count.
  - Set `last_gnt` to the latched index, then go to IDLE.
  - `gnt` drops on the cycle after DONE.
- `pb_out` is sampled only in RUN; pulses seen in IDLE, LOAD or DONE are ignored.
- Deasserting `req[id]` mid-operation has no effect; the operation completes and the response is still issued.
- A new request is considered only in IDLE, so there is at least one IDLE cycle between back-to-back operations.
- `req` changes on non-granted lines never disturb the operation in flight.
- Operands are latched in IDLE; changes to `req_w`/`req_x` after that are ignored.

## Timing
- Reset values:
  - state IDLE and `last_gnt`=N_REQ−1, so requester 0 wins first;
  - `gnt`, `pb_in_rdy`, `pb_w`, `pb_x`, `rsp_valid`, `rsp_id`, `rsp_prod` and `busy` all 0;
  - both counters 0.
- `pb_w`/`pb_x` read 0 in IDLE and DONE.
- `rsp_prod` and `rsp_id` hold their last value until the next DONE.
- Cycle schedule, with cycle 0 being the IDLE cycle that samples `req`:
  - cycle 1: LOAD;
  - cycles 2 … WINDOW+1: RUN;
  - cycle WINDOW+2: DONE, `rsp_valid`=1;
  - cycle WINDOW+3: IDLE.
- Latency from request sample to `rsp_valid` is WINDOW+2 cycles. Issue period is WINDOW+4 cycles per operation.
- `reset` asserted in any state: on the next edge the FSM returns to IDLE with all outputs at reset values. No response is issued for an interrupted operation and the partial count is discarded.
- If `reset` and `req` are high together, `reset` wins.

## Configuration
- Macro: `PROD_SCHED_ZERO_SKIP_EN`.
- **Defined:** in IDLE, if the selected requester's w==0 or x==0, the FSM goes straight to DONE on the next cycle.
  - No LOAD and no `pb_in_rdy` pulse.
  - `rsp_prod`=0, latency 1 cycle.
  - `gnt` is high for that DONE cycle only, and `last_gnt` updates as normal.
- **Undefined:** zero operands take the full LOAD/RUN path.

## Test plan
Bench uses N_REQ=4, WINDOW=225 and a product-block model that emits w·x pulses starting the cycle after `pb_in_rdy`.
- Single request: `req`[2] with w=3, x=5 → `pb_in_rdy` at cycle 1 with `pb_w`=3, `pb_x`=5; `rsp_valid` at cycle 227 with `rsp_id`=2, `rsp_prod`=15.
- Fairness: all four `req` held high from reset → grant order 0,1,2,3,0; `rsp_valid` strobes spaced 229 cycles apart.
- Extremes: w=15, x=15 → `rsp_prod`=225. Re-run with CW=4 and w=4, x=5 → `rsp_prod`=15 (saturated).
- Stray pulses: `pb_out` forced high in IDLE and in DONE, with w=1, x=1 → `rsp_prod`=1.
- Reset mid-operation: `reset` at cycle 100 of RUN → next cycle has `busy`=0 and all outputs 0; no `rsp_valid` appears. A following request on `req`[0] completes normally.
- Zero operand: w=0, x=7 → with `PROD_SCHED_ZERO_SKIP_EN`, `rsp_valid` at cycle 1 with `rsp_prod`=0 and `pb_in_rdy` never asserted. Without the macro, `rsp_valid` at cycle 227 with `rsp_prod`=0.
